fft_bin_scheduler: RTL and testbench
====================================

Name: fft_bin_scheduler

Overview:
- Sequences the FFT output stream into a per-frame set of LED levels.
- Hunts for the FFT frame sync and captures the first BINS bins of each frame.
- Per bin, computes |X|^2 on one shared multiplier over two cycles, scales, saturates and optionally applies peak-hold with decay.
- Publishes a complete, double-buffered level vector to the gamma/PWM stage with a one-cycle frame strobe.
- Sits between the FFT core and the LED gamma LUT/PWM instances.

Parameters:
- WIDTH, 12: signed width of FFT real/imag outputs.
- BINS, 8: bins captured per frame; 1..16.
- LEVEL_W, 8: output level width; saturation value is 2^LEVEL_W-1.
- SHIFT, 6: right shift applied to |X|^2 before saturation.
- HOLD, 1: 1 enables peak-hold/decay; 0 publishes the raw saturated magnitude.
- DECAY, 16: per-frame decrement of the held level, unsigned, LEVEL_W bits.

Ports:
- clk, in, 1: system clock (32 MHz PLL domain).
- reset_n, in, 1: asynchronous, active-low reset.
- i_enable, in, 1: 0 forces HUNT and blocks publishing.
- i_ce, in, 1: FFT output valid strobe (the ADC ready strobe).
- i_sync, in, 1: FFT frame sync; qualified by i_ce; marks bin 0.
- i_real, in, WIDTH: signed FFT real output.
- i_imag, in, WIDTH: signed FFT imag output.
- i_clr_err, in, 1: clears the sticky error flags.
- o_levels, out, BINS*LEVEL_W: published levels; bin b at [b*LEVEL_W +: LEVEL_W].
- o_frame, out, 1: one-cycle pulse when o_levels updates.
- o_busy, out, 1: high in SQ_RE, SQ_IM, COMMIT and PUBLISH.
- o_overrun, out, 1: sticky; an i_ce arrived while busy.
- o_resync, out, 1: sticky; i_sync seen mid-capture.

Behaviour:
- Reset (async, reset_n=0): state=HUNT, bin_idx=0, accumulator=0, shadow and published levels all 0, o_frame=0, o_overrun=0, o_resync=0.
- Sample capture: a sample is any cycle with i_ce=1. i_real and i_imag are registered on that cycle. Samples with i_ce=0 are ignored.
- HUNT: on i_ce & i_sync & i_enable -> capture, bin_idx=0, go to SQ_RE. Any other i_ce is ignored, with no error flag.
- WAIT: on i_ce -> capture, go to SQ_RE.
  - If i_sync is also high and bin_idx!=0: set o_resync, restart at bin_idx=0; the shadow buffer keeps its partial contents.
- SQ_RE: acc = re*re, unsigned, 2*WIDTH+1 bits. Go to SQ_IM.
- SQ_IM: acc = acc + im*im. Go to COMMIT.
- COMMIT:
  - mag = acc >> SHIFT, saturated to 2^LEVEL_W-1.
  - If HOLD=1: decayed = pub[bin_idx] - DECAY, floored at 0; shadow[bin_idx] = max(mag, decayed).
  - If HOLD=0: shadow[bin_idx] = mag.
  - If bin_idx==BINS-1, go to PUBLISH. Otherwise bin_idx+1 and go to WAIT.
- PUBLISH: copy all shadow entries to o_levels in one cycle, assert o_frame for that cycle, bin_idx=0, go to HUNT.
- Latency: i_ce of the last bin at cycle t -> o_frame and new o_levels visible at t+4. The minimum i_ce spacing the block accepts is 4 cycles.
- Overrun: i_ce while busy sets o_overrun. The sample is dropped and the FSM is unaffected. An i_ce on the same cycle the FSM returns to WAIT/HUNT is accepted.
- i_enable=0: state goes to HUNT on the next clk. Any frame in flight is abandoned, o_levels is held, and o_frame stays 0.
- i_clr_err: clears both sticky flags. If it coincides with a new error event, the flag is set (set wins).
- o_levels only changes in PUBLISH and is stable between o_frame pulses.

Test Plan:
- WIDTH=12, SHIFT=6, HOLD=0, ce every 10 cycles, sync on sample 0; bin0 re=100 im=0, bin1 re=0 im=-64, others 0 -> o_frame 4 cycles after 8th ce; level0=156, level1=64, rest 0.
- Saturation: bin0 re=200 im=0 (40000>>6=625); bin1 re=-2048 im=-2048 -> both levels 255, no accumulator wrap.
- Peak-hold (HOLD=1, DECAY=16): bin0 = 156, then 0, then 0 over three frames -> published 156, 140, 124. A bin with pub=10 and new=0 -> 0 (floored).
- Overrun: ce spacing 2 cycles mid-frame -> o_overrun=1, dropped sample never written, i_clr_err pulse -> o_overrun=0.
- Resync: sync asserted again at bin 3 -> o_resync=1, the frame restarts, o_frame appears only after 8 more bins.
- Reset/enable: reset_n low during SQ_IM -> all outputs 0 immediately. i_enable low mid-frame -> no o_frame and o_levels held; after re-enable, the first sync restarts capture.

Source files
------------

// File: rtl/fft_bin_scheduler.sv
// FFT bin scheduler: captures the first BINS bins of each FFT frame, squares them
// on one shared multiplier, and publishes a double-buffered LED level vector.
module fft_bin_scheduler #(
  parameter int WIDTH   = 12,
  parameter int BINS    = 8,
  parameter int LEVEL_W = 8,
  parameter int SHIFT   = 6,
  parameter int HOLD    = 1,
  parameter int DECAY   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_enable,
  input  logic                    i_ce,
  input  logic                    i_sync,
  input  logic signed [WIDTH-1:0] i_real,
  input  logic signed [WIDTH-1:0] i_imag,
  input  logic                    i_clr_err,
  output logic [BINS*LEVEL_W-1:0] o_levels,
  output logic                    o_frame,
  output logic                    o_busy,
  output logic                    o_overrun,
  output logic                    o_resync
);
  localparam int ACC_W  = 2 * WIDTH + 1;
  localparam int BIDX_W = (BINS > 1) ? $clog2(BINS) : 1;
  localparam logic [LEVEL_W-1:0] SAT      = '1;
  localparam logic [LEVEL_W-1:0] DEC      = LEVEL_W'(DECAY);
  localparam logic [BIDX_W-1:0]  LAST_BIN = BIDX_W'(BINS - 1);

  typedef enum logic [2:0] {
    S_HUNT, S_WAIT, S_SQ_RE, S_SQ_IM, S_COMMIT, S_PUBLISH
  } state_t;

  state_t                  state_q, state_d;
  logic [BIDX_W-1:0]       bin_idx_q, bin_idx_d;
  logic signed [WIDTH-1:0] re_q, re_d, im_q, im_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [LEVEL_W-1:0]      shadow_q [BINS];
  logic [LEVEL_W-1:0]      shadow_d [BINS];
  logic [LEVEL_W-1:0]      levels_q [BINS];
  logic [LEVEL_W-1:0]      levels_d [BINS];
  logic                    frame_q, frame_d, busy_q, busy_d;
  logic                    overrun_q, overrun_d, resync_q, resync_d;

  logic signed [2*WIDTH-1:0] op_ext, sq;
  logic [ACC_W-1:0]          shifted;
  logic [LEVEL_W-1:0]        mag, pub, decayed, held, level;

  // Shared squarer: real part in SQ_RE, imaginary part otherwise.
  always_comb begin
    op_ext  = (state_q == S_SQ_RE) ? (2*WIDTH)'(re_q) : (2*WIDTH)'(im_q);
    sq      = op_ext * op_ext;
    shifted = acc_q >> SHIFT;
    mag     = (shifted > ACC_W'(SAT)) ? SAT : shifted[LEVEL_W-1:0];
    pub     = levels_q[bin_idx_q];
    decayed = (pub > DEC) ? pub - DEC : '0;
    held    = (mag > decayed) ? mag : decayed;
    level   = (HOLD != 0) ? held : mag;
  end

  always_comb begin
    // NOTE: every _d gets a default before the case so no path infers a latch.
    state_d   = state_q;
    bin_idx_d = bin_idx_q;
    re_d      = re_q;
    im_d      = im_q;
    acc_d     = acc_q;
    shadow_d  = shadow_q;
    levels_d  = levels_q;
    frame_d   = 1'b0;
    overrun_d = overrun_q & ~i_clr_err;
    resync_d  = resync_q & ~i_clr_err;
    if (i_ce && busy_q) overrun_d = 1'b1;

    if (!i_enable) begin
      state_d   = S_HUNT;
      bin_idx_d = '0;
    end else begin
      case (state_q)
        S_HUNT: if (i_ce && i_sync) begin
          re_d      = i_real;
          im_d      = i_imag;
          bin_idx_d = '0;
          state_d   = S_SQ_RE;
        end
        S_WAIT: if (i_ce) begin
          re_d    = i_real;
          im_d    = i_imag;
          state_d = S_SQ_RE;
          if (i_sync && bin_idx_q != '0) begin
            resync_d  = 1'b1;
            bin_idx_d = '0;
          end
        end
        S_SQ_RE: begin
          acc_d   = {1'b0, sq};
          state_d = S_SQ_IM;
        end
        S_SQ_IM: begin
          acc_d   = acc_q + {1'b0, sq};
          state_d = S_COMMIT;
        end
        S_COMMIT: begin
          shadow_d[bin_idx_q] = level;
          if (bin_idx_q == LAST_BIN) begin
            // Publish on this edge so o_frame and the new levels appear together.
            levels_d = shadow_d;
            frame_d  = 1'b1;
            state_d  = S_PUBLISH;
          end else begin
            bin_idx_d = bin_idx_q + 1'b1;
            state_d   = S_WAIT;
          end
        end
        S_PUBLISH: begin
          bin_idx_d = '0;
          state_d   = S_HUNT;
        end
        default: state_d = S_HUNT;
      endcase
    end
    busy_d = state_d inside {S_SQ_RE, S_SQ_IM, S_COMMIT, S_PUBLISH};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_HUNT;
      bin_idx_q <= '0;
      re_q      <= '0;
      im_q      <= '0;
      acc_q     <= '0;
      frame_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      resync_q  <= 1'b0;
      // NOTE: the level buffers are small register arrays, not RAM, so they
      // take the async reset and the LEDs come up dark.
      for (int b = 0; b < BINS; b++) begin
        shadow_q[b] <= '0;
        levels_q[b] <= '0;
      end
    end else begin
      // NOTE: non-blocking throughout so every flop samples pre-edge values.
      state_q   <= state_d;
      bin_idx_q <= bin_idx_d;
      re_q      <= re_d;
      im_q      <= im_d;
      acc_q     <= acc_d;
      frame_q   <= frame_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      resync_q  <= resync_d;
      shadow_q  <= shadow_d;
      levels_q  <= levels_d;
    end
  end

  always_comb begin
    o_levels = '0;
    for (int b = 0; b < BINS; b++) o_levels[b*LEVEL_W +: LEVEL_W] = levels_q[b];
  end

  assign o_frame   = frame_q;
  assign o_busy    = busy_q;
  assign o_overrun = overrun_q;
  assign o_resync  = resync_q;
endmodule

// File: tb/tb_fft_bin_scheduler.sv
// Scoreboard bench: two instances (HOLD=0 and HOLD=1) share one stimulus stream;
// expected frames are queued at issue time and a monitor checks each o_frame.
`timescale 1ns/1ps
module tb_fft_bin_scheduler;
  localparam int WIDTH = 12, BINS = 8, LEVEL_W = 8;

  logic clk = 1'b0, reset_n = 1'b0, i_enable = 1'b0, i_ce = 1'b0, i_sync = 1'b0;
  logic i_clr_err = 1'b0;
  logic signed [WIDTH-1:0] i_real = '0, i_imag = '0;
  logic [BINS*LEVEL_W-1:0] lv0, lv1;
  logic fr0, fr1, busy0, busy1, ovr0, ovr1, rs0, rs1;

  fft_bin_scheduler #(.WIDTH(WIDTH), .BINS(BINS), .LEVEL_W(LEVEL_W), .SHIFT(6),
                      .HOLD(0), .DECAY(16)) u_raw (
    .clk(clk), .reset_n(reset_n), .i_enable(i_enable), .i_ce(i_ce), .i_sync(i_sync),
    .i_real(i_real), .i_imag(i_imag), .i_clr_err(i_clr_err), .o_levels(lv0),
    .o_frame(fr0), .o_busy(busy0), .o_overrun(ovr0), .o_resync(rs0));

  fft_bin_scheduler #(.WIDTH(WIDTH), .BINS(BINS), .LEVEL_W(LEVEL_W), .SHIFT(6),
                      .HOLD(1), .DECAY(16)) u_hold (
    .clk(clk), .reset_n(reset_n), .i_enable(i_enable), .i_ce(i_ce), .i_sync(i_sync),
    .i_real(i_real), .i_imag(i_imag), .i_clr_err(i_clr_err), .o_levels(lv1),
    .o_frame(fr1), .o_busy(busy1), .o_overrun(ovr1), .o_resync(rs1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [63:0] lv;
    int          cyc;
  } exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;

  always @(negedge clk) begin
    if (reset_n && fr0) begin
      if (q0.size() == 0) check("raw_unexpected_frame", 64'd1, 64'd0);
      else begin
        e0 = q0.pop_front();
        check("raw_levels", lv0, e0.lv);
        check("raw_latency", 64'(cyc), 64'(e0.cyc));
      end
    end
    if (reset_n && fr1) begin
      if (q1.size() == 0) check("hold_unexpected_frame", 64'd1, 64'd0);
      else begin
        e1 = q1.pop_front();
        check("hold_levels", lv1, e1.lv);
        check("hold_latency", 64'(cyc), 64'(e1.cyc));
      end
    end
  end

  function automatic logic [63:0] L(input int b0, b1, b2, b3, b4, b5, b6, b7);
    return {b7[7:0], b6[7:0], b5[7:0], b4[7:0], b3[7:0], b2[7:0], b1[7:0], b0[7:0]};
  endfunction

  int fre[BINS], fim[BINS];

  task automatic clear_frame();
    for (int b = 0; b < BINS; b++) begin
      fre[b] = 0;
      fim[b] = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic pulse(input int re, input int im, input logic sync);
    i_real = WIDTH'(re);
    i_imag = WIDTH'(im);
    i_sync = sync;
    i_ce   = 1'b1;
    idle(1);
    i_ce   = 1'b0;
    i_sync = 1'b0;
  endtask

  // One frame at 10-cycle spacing; ovr_bin >= 0 inserts a 2-cycle-spaced extra ce.
  task automatic send_frame(input logic [63:0] exp_raw, input logic [63:0] exp_hold,
                            input int ovr_bin);
    for (int b = 0; b < BINS; b++) begin
      if (b == BINS - 1) begin
        q0.push_back('{lv: exp_raw, cyc: cyc + 4});
        q1.push_back('{lv: exp_hold, cyc: cyc + 4});
      end
      pulse(fre[b], fim[b], b == 0);
      if (b == ovr_bin) begin
        idle(1);
        pulse(2047, 2047, 1'b0);
        idle(7);
      end else begin
        idle(9);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    idle(3);
    check("reset_levels_raw", lv0, 64'd0);
    check("reset_levels_hold", lv1, 64'd0);
    check("reset_flags", {fr0, busy0, ovr0, rs0, fr1, busy1, ovr1, rs1}, 64'd0);
    reset_n = 1'b1;
    i_enable = 1'b1;
    idle(2);

    // Basic magnitudes, then two empty frames to watch the hold decay.
    clear_frame(); fre[0] = 100; fim[1] = -64;
    send_frame(L(156, 64, 0, 0, 0, 0, 0, 0), L(156, 64, 0, 0, 0, 0, 0, 0), -1);
    clear_frame();
    send_frame(L(0, 0, 0, 0, 0, 0, 0, 0), L(140, 48, 0, 0, 0, 0, 0, 0), -1);
    clear_frame();
    send_frame(L(0, 0, 0, 0, 0, 0, 0, 0), L(124, 32, 0, 0, 0, 0, 0, 0), -1);

    // Level 10 on bin 2, then it decays to a floored 0.
    clear_frame(); fre[2] = 26;
    send_frame(L(0, 0, 10, 0, 0, 0, 0, 0), L(108, 16, 10, 0, 0, 0, 0, 0), -1);
    clear_frame();
    send_frame(L(0, 0, 0, 0, 0, 0, 0, 0), L(92, 0, 0, 0, 0, 0, 0, 0), -1);

    // Saturation, including the largest-magnitude corner.
    clear_frame(); fre[0] = 200; fre[1] = -2048; fim[1] = -2048;
    send_frame(L(255, 255, 0, 0, 0, 0, 0, 0), L(255, 255, 0, 0, 0, 0, 0, 0), -1);

    // Overrun: extra ce two cycles after bin 3 is dropped.
    check("overrun_pre", {ovr0, ovr1}, 64'd0);
    clear_frame(); fre[3] = 64;
    send_frame(L(0, 0, 0, 64, 0, 0, 0, 0), L(239, 239, 0, 64, 0, 0, 0, 0), 3);
    check("overrun_set", {ovr0, ovr1}, 64'd3);
    check("resync_quiet", {rs0, rs1}, 64'd0);
    i_clr_err = 1'b1; idle(1); i_clr_err = 1'b0; idle(1);
    check("overrun_clr", {ovr0, ovr1}, 64'd0);

    // Resync: three bins, then a sync sample restarts the frame at bin 0.
    pulse(100, 0, 1'b1); idle(9);
    pulse(100, 0, 1'b0); idle(9);
    pulse(100, 0, 1'b0); idle(9);
    clear_frame(); fim[0] = 64; fre[1] = 26;
    send_frame(L(64, 10, 0, 0, 0, 0, 0, 0), L(223, 223, 0, 48, 0, 0, 0, 0), -1);
    check("resync_set", {rs0, rs1}, 64'd3);
    i_clr_err = 1'b1; idle(1); i_clr_err = 1'b0; idle(1);
    check("resync_clr", {rs0, rs1}, 64'd0);

    // Disable during the last bin's squaring: no frame, levels held.
    for (int b = 0; b < BINS; b++) begin
      pulse(100, 0, b == 0);
      if (b < BINS - 1) idle(9);
    end
    idle(1);
    i_enable = 1'b0;
    idle(12);
    check("disable_hold_raw", lv0, L(64, 10, 0, 0, 0, 0, 0, 0));
    check("disable_hold_hold", lv1, L(223, 223, 0, 48, 0, 0, 0, 0));
    check("disable_idle", {busy0, busy1}, 64'd0);
    i_enable = 1'b1;
    idle(3);
    pulse(2047, 2047, 1'b0); idle(9);
    clear_frame(); fre[0] = 100;
    send_frame(L(156, 0, 0, 0, 0, 0, 0, 0), L(207, 207, 0, 32, 0, 0, 0, 0), -1);

    // Async reset while in SQ_IM clears everything at once.
    pulse(100, 0, 1'b1);
    idle(1);
    check("busy_in_sq_im", {busy0, busy1}, 64'd3);
    reset_n = 1'b0;
    #1;
    check("async_reset_levels", {lv0, lv1}, 64'd0);
    check("async_reset_flags", {fr0, busy0, ovr0, rs0, fr1, busy1, ovr1, rs1}, 64'd0);
    idle(2);
    reset_n = 1'b1;
    idle(2);
    clear_frame(); fre[0] = 100; fim[1] = -64;
    send_frame(L(156, 64, 0, 0, 0, 0, 0, 0), L(156, 64, 0, 0, 0, 0, 0, 0), -1);

    idle(10);
    check("raw_frames_outstanding", 64'(q0.size()), 64'd0);
    check("hold_frames_outstanding", 64'(q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
